// File: rtl/seq_bcd_alu.sv
// seq_bcd_alu: multi-cycle BCD ALU (SUM/SUB/MUL/DIV) on WIDTH-bit unsigned operands.
// The operation runs in CALC: SUM/SUB take one edge. MUL takes WIDTH edges of shift-add.
// DIV takes WIDTH edges of restoring division.
// The binary result is then converted to packed BCD in CONV, which takes RW double-dabble edges.
// Handshake: start (sampled in IDLE only) / busy / one-cycle done.
// Optional feature macro: SEQ_BCD_ALU_SIGNED_SUB_EN.
// When this macro is defined, SUB with in1<in2 yields the magnitude and sets neg=1 instead of error.
module seq_bcd_alu #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in1,
    input  logic [WIDTH-1:0]      in2,
    input  logic [1:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  zero,
    output logic                  error,
    output logic                  neg
);

    localparam int RW    = 2 * WIDTH;
    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(RW + 1);

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] MAX_BIN = (64'd1 << RW) - 64'd1;

    // The BCD field must be able to hold the largest RW-bit result.
    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_check
            $error("seq_bcd_alu: DIGITS too small for a 2*WIDTH-bit result");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_CONV,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, rem_reg;
    logic [1:0]       op_reg;
    logic             div0_reg, under_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [RW-1:0]    acc_reg, bin_reg;
    logic [BW-1:0]    bcd_sh_reg, bcd_reg;
    logic             zero_reg, error_reg;

    logic [RW-1:0]    a_ext, b_ext, acc_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             calc_last, conv_last;
    logic [BW-1:0]    bcd_adj, bcd_shifted;

    assign calc_last = (op_reg[1] == 1'b0) || (cnt_reg == CNT_W'(WIDTH - 1));
    assign conv_last = (cnt_reg == CNT_W'(RW - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (calc_last) state_next = S_CONV;
            end
            S_CONV: begin
                busy = 1'b1;
                if (conv_last) state_next = S_DONE;
            end
            default: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    // One arithmetic step: the full result for SUM/SUB, one partial product or one quotient bit otherwise.
    always_comb begin
        a_ext     = RW'(a_reg);
        b_ext     = RW'(b_reg);
        rem_shift = {rem_reg, a_reg[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, b_reg});
        rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, b_reg}) : rem_shift[WIDTH-1:0];
        acc_next  = acc_reg;
        case (op_reg)
            OP_SUM:  acc_next = a_ext + b_ext;
            OP_SUB:  acc_next = under_reg ? (b_ext - a_ext) : (a_ext - b_ext);
            OP_MUL:  acc_next = {acc_reg[RW-2:0], 1'b0} + (b_reg[WIDTH-1] ? a_ext : '0);
            default: acc_next = {acc_reg[RW-2:0], q_bit};
        endcase
    end

    // Double-dabble adjust: add 3 to every digit that is 5 or more before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dd
            assign bcd_adj[gi*4 +: 4] = (bcd_sh_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_sh_reg[gi*4 +: 4] + 4'd3
                                      : bcd_sh_reg[gi*4 +: 4];
        end
    endgenerate
    // The top bit that shifts out is always zero because of the DIGITS bound.
    assign bcd_shifted = BW'({bcd_adj, bin_reg[RW-1]});

`ifdef SEQ_BCD_ALU_SIGNED_SUB_EN
    logic neg_reg;
    assign neg = neg_reg;
`else
    assign neg = 1'b0;
`endif

    assign bcd   = bcd_reg;
    assign zero  = zero_reg;
    assign error = error_reg;

    // Datapath: latch operands, iterate the arithmetic, convert, and publish results on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            op_reg     <= '0;
            div0_reg   <= 1'b0;
            under_reg  <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            bin_reg    <= '0;
            bcd_sh_reg <= '0;
            bcd_reg    <= '0;
            zero_reg   <= 1'b0;
            error_reg  <= 1'b0;
`ifdef SEQ_BCD_ALU_SIGNED_SUB_EN
            neg_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= in1;
                        b_reg     <= in2;
                        op_reg    <= op;
                        div0_reg  <= (op == OP_DIV) && (in2 == '0);
                        under_reg <= (op == OP_SUB) && (in1 < in2);
                        rem_reg   <= '0;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                end
                S_CALC: begin
                    acc_reg <= acc_next;
                    if (op_reg == OP_MUL) b_reg <= b_reg << 1;
                    if (op_reg == OP_DIV) begin
                        a_reg   <= a_reg << 1;
                        rem_reg <= rem_next;
                    end
                    if (calc_last) begin
                        cnt_reg    <= '0;
                        bin_reg    <= acc_next;
                        bcd_sh_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_CONV: begin
                    bin_reg    <= bin_reg << 1;
                    bcd_sh_reg <= bcd_shifted;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (conv_last) begin
                        if (div0_reg) begin
                            bcd_reg   <= {DIGITS{4'hF}};
                            error_reg <= 1'b1;
                            zero_reg  <= 1'b0;
`ifdef SEQ_BCD_ALU_SIGNED_SUB_EN
                            neg_reg   <= 1'b0;
`endif
                        end else if (under_reg) begin
`ifdef SEQ_BCD_ALU_SIGNED_SUB_EN
                            bcd_reg   <= bcd_shifted;
                            error_reg <= 1'b0;
                            neg_reg   <= 1'b1;
`else
                            bcd_reg   <= '0;
                            error_reg <= 1'b1;
`endif
                            zero_reg  <= 1'b0;
                        end else begin
                            bcd_reg   <= bcd_shifted;
                            error_reg <= 1'b0;
                            zero_reg  <= (acc_reg == '0);
`ifdef SEQ_BCD_ALU_SIGNED_SUB_EN
                            neg_reg   <= 1'b0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
